// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one DW-bit SPI master among NUM_REQ requesters.
// Optional WAIT-state watchdog and timeout_err port enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DW          = 12,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [DW-1:0]         rsp_data,
   output logic                  busy,
   output logic                  spi_start,
   output logic [DW-1:0]         spi_din,
   input  logic                  spi_done,
   input  logic [DW-1:0]         spi_dout
`ifdef SPI_ARB_TIMEOUT_EN
   ,
   output logic                  timeout_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   ptr_q, ptr_d;          // one-hot round-robin pointer
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]        rsp_data_q, rsp_data_d;
   logic                 busy_q, busy_d;
   logic                 spi_start_q, spi_start_d;
   logic [DW-1:0]        spi_din_q, spi_din_d;

   logic [NUM_REQ-1:0]   hi_mask;
   logic [NUM_REQ-1:0]   req_hi;
   logic [NUM_REQ-1:0]   sel_oh;
   logic [NUM_REQ-1:0]   gnt_rot;
   logic [DW-1:0]        din_sel;
   logic [DW-1:0][NUM_REQ-1:0] data_t;
   logic                 done_ok;
   logic                 finish;

   // Requests at or above the pointer win; otherwise wrap to the lowest set bit.
   assign hi_mask = ~(ptr_q - NUM_REQ'(1));
   assign req_hi  = req & hi_mask;
   assign sel_oh  = (|req_hi) ? (req_hi & (~req_hi + NUM_REQ'(1)))
                              : (req & (~req + NUM_REQ'(1)));

   generate
      if (NUM_REQ == 1) begin : g_rot_single
         assign gnt_rot = NUM_REQ'(1);
      end else begin : g_rot_multi
         assign gnt_rot = {gnt_q[NUM_REQ-2:0], gnt_q[NUM_REQ-1]};
      end
   endgenerate

   // Transposed write words so each output bit is an AND-OR over the one-hot select.
   generate
      for (genvar gb = 0; gb < DW; gb++) begin : g_bit
         for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_t[gb][gi] = req_data[gi*DW + gb];
         end
         assign din_sel[gb] = |(data_t[gb] & sel_oh);
      end
   endgenerate

   // The master's done pulse is ignored in the cycle the start pulse is still out.
   assign done_ok = (state_q == S_WAIT) && !spi_start_q && spi_done;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
   logic          tmo_hit;

   assign tmo_hit     = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT_CYC - 1));
   assign finish      = done_ok || tmo_hit;
   assign timeout_err = tmo_q;
`else
   assign finish = done_ok;
   generate
      if (TIMEOUT_CYC < 1) begin : g_timeout_unused
      end
   endgenerate
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      busy_d      = busy_q;
      spi_start_d = 1'b0;
      spi_din_d   = spi_din_q;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      tmo_d       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               gnt_d       = sel_oh;
               spi_din_d   = din_sel;
               spi_start_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         S_WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_d = cnt_q + CW'(1);
            tmo_d = finish && !done_ok;
`endif
            if (finish) begin
               rsp_data_d  = done_ok ? spi_dout : {DW{1'b1}};
               rsp_valid_d = gnt_q;
               gnt_d       = '0;
               busy_d      = 1'b0;
               ptr_d       = gnt_rot;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= NUM_REQ'(1);
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         spi_start_q <= 1'b0;
         spi_din_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         tmo_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         spi_start_q <= spi_start_d;
         spi_din_q   <= spi_din_d;
`ifdef SPI_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;
   assign spi_start = spi_start_q;
   assign spi_din   = spi_din_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: table of transactions plus hand-written corner sequences.
// Responses are checked by a scoreboard queue filled when each transaction is launched.
module tb_spi_req_arbiter;
   localparam int N  = 4;
   localparam int DW = 12;
   localparam logic [N*DW-1:0] ALL = {12'h444, 12'h333, 12'h222, 12'h111};
   localparam logic [N*DW-1:0] T1  = {12'h444, 12'h333, 12'h0F5, 12'h111};

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            busy;
   logic            spi_start;
   logic [DW-1:0]   spi_din;
   logic            spi_done = 1'b0;
   logic [DW-1:0]   spi_dout = '0;
`ifdef SPI_ARB_TIMEOUT_EN
   logic            timeout_err;
`endif

   spi_req_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT_CYC(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .spi_start (spi_start),
      .spi_din   (spi_din),
      .spi_done  (spi_done),
      .spi_dout  (spi_dout)
`ifdef SPI_ARB_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]    req;
      logic [N*DW-1:0] data;
      int              delay;
      logic [DW-1:0]   dout;
      logic [N-1:0]    gnt;
      logic [DW-1:0]   din;
   } vec_t;

   typedef struct {
      logic [N-1:0]  gnt;
      logic [DW-1:0] data;
      logic          tmo;
   } rsp_t;

   rsp_t sb_q[$];
   rsp_t mon_e;
   vec_t tbl[12];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [N-1:0] g, input logic [DW-1:0] d, input logic t);
      rsp_t r;
      r.gnt  = g;
      r.data = d;
      r.tmo  = t;
      sb_q.push_back(r);
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (spi_start) begin
            ok = 1'b1;
            break;
         end
      end
      chk("start_seen", 64'(ok), 64'd1);
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && rsp_valid !== '0) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: rsp_valid=%b rsp_data=%h with nothing expected", rsp_valid, rsp_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(mon_e.gnt));
            chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
`ifdef SPI_ARB_TIMEOUT_EN
            chk("timeout_err", 64'(timeout_err), 64'(mon_e.tmo));
`endif
         end
      end
   end

   task automatic run_txn(input vec_t v, input int idx);
      bit ok;
      req      = v.req;
      req_data = v.data;
      wait_start(ok);
      if (ok) begin
         chk("gnt", 64'(gnt), 64'(v.gnt));
         chk("spi_din", 64'(spi_din), 64'(v.din));
         chk("busy_high", 64'(busy), 64'd1);
         req_data = ~v.data;
         push_exp(v.gnt, v.dout, 1'b0);
         tick();
         chk("start_one_cycle", 64'(spi_start), 64'd0);
         repeat (v.delay - 1) tick();
         chk("din_held", 64'(spi_din), 64'(v.din));
         spi_done = 1'b1;
         spi_dout = v.dout;
         tick();
         spi_done = 1'b0;
         spi_dout = 12'(($urandom));
         chk("busy_low", 64'(busy), 64'd0);
         chk("gnt_low", 64'(gnt), 64'd0);
         tick();
         chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
         chk("rsp_data_held", 64'(rsp_data), 64'(v.dout));
         $display("txn %0d: req=%b gnt=%b din=%h rsp=%h", idx, v.req, v.gnt, v.din, v.dout);
      end
   endtask

   initial begin
      bit ok;
      bit seen;
      int n;
      tbl[0]  = '{4'b1111, ALL, 2, 12'h5A1, 4'b0001, 12'h111};
      tbl[1]  = '{4'b1111, ALL, 3, 12'h5A2, 4'b0010, 12'h222};
      tbl[2]  = '{4'b1111, ALL, 1, 12'h5A3, 4'b0100, 12'h333};
      tbl[3]  = '{4'b1111, ALL, 4, 12'h5A4, 4'b1000, 12'h444};
      tbl[4]  = '{4'b1111, ALL, 2, 12'h5A5, 4'b0001, 12'h111};
      tbl[5]  = '{4'b1000, ALL, 2, 12'h0C3, 4'b1000, 12'h444};
      tbl[6]  = '{4'b1001, ALL, 2, 12'h0C9, 4'b0001, 12'h111};
      tbl[7]  = '{4'b1001, ALL, 2, 12'h9C0, 4'b1000, 12'h444};
      tbl[8]  = '{4'b0010, T1,  5, 12'hA3C, 4'b0010, 12'h0F5};
      tbl[9]  = '{4'b0011, ALL, 3, 12'hFFE, 4'b0001, 12'h111};
      tbl[10] = '{4'b0110, ALL, 1, 12'h001, 4'b0010, 12'h222};
      tbl[11] = '{4'b0001, ALL, 6, 12'h800, 4'b0001, 12'h111};

      // Reset state
      req_data = ALL;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_spi_start", 64'(spi_start), 64'd0);
      chk("rst_spi_din", 64'(spi_din), 64'd0);
`ifdef SPI_ARB_TIMEOUT_EN
      chk("rst_timeout_err", 64'(timeout_err), 64'd0);
`endif
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) run_txn(tbl[i], i);
      req      = '0;
      req_data = ALL;
      tick();

      // spi_done while idle is ignored
      spi_done = 1'b1;
      spi_dout = 12'hBAD;
      tick();
      spi_done = 1'b0;
      chk("spur_idle_busy", 64'(busy), 64'd0);
      chk("spur_idle_rsp", 64'(rsp_valid), 64'd0);
      tick();
      chk("spur_idle_start", 64'(spi_start), 64'd0);

      // spi_done during the start cycle is ignored
      req = 4'b0100;
      wait_start(ok);
      req = '0;
      chk("spur_gnt", 64'(gnt), 64'b0100);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      chk("spur_start_rsp", 64'(rsp_valid), 64'd0);
      chk("spur_start_busy", 64'(busy), 64'd1);
      chk("spur_start_gnt", 64'(gnt), 64'b0100);
      push_exp(4'b0100, 12'h3C3, 1'b0);
      tick();
      spi_done = 1'b1;
      spi_dout = 12'h3C3;
      tick();
      spi_done = 1'b0;
      chk("spur_done_busy", 64'(busy), 64'd0);
      tick();
      $display("txn spurious: gnt=0100 rsp=3c3");

      // Asynchronous reset while a transfer is in flight
      req = 4'b0001;
      wait_start(ok);
      req = '0;
      chk("rw_gnt", 64'(gnt), 64'b0001);
      rst_n = 1'b0;
      #1;
      chk("rw_gnt_clr", 64'(gnt), 64'd0);
      chk("rw_busy_clr", 64'(busy), 64'd0);
      chk("rw_start_clr", 64'(spi_start), 64'd0);
      chk("rw_rsp_data_clr", 64'(rsp_data), 64'd0);
      chk("rw_din_clr", 64'(spi_din), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      run_txn('{4'b0100, ALL, 2, 12'h77E, 4'b0100, 12'h333}, 100);
      req = '0;

`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog completion after 64 WAIT cycles
      req = 4'b0010;
      wait_start(ok);
      req = '0;
      push_exp(4'b0010, 12'hFFF, 1'b1);
      seen = 1'b0;
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (rsp_valid !== '0) begin
            seen = 1'b1;
            n = i;
            break;
         end
      end
      chk("wdog_seen", 64'(seen), 64'd1);
      chk("wdog_latency", 64'(n), 64'd64);
      tick();
      chk("wdog_err_pulse", 64'(timeout_err), 64'd0);
      chk("wdog_busy", 64'(busy), 64'd0);
      $display("txn watchdog: gnt=0010 rsp=fff cycles=%0d", n);
      tick();

      // spi_done in the timeout cycle wins
      req = 4'b0010;
      wait_start(ok);
      req = '0;
      push_exp(4'b0010, 12'h5C5, 1'b0);
      repeat (63) tick();
      spi_done = 1'b1;
      spi_dout = 12'h5C5;
      tick();
      spi_done = 1'b0;
      chk("wdog_race_busy", 64'(busy), 64'd0);
      tick();
      $display("txn watchdog race: gnt=0010 rsp=5c5");
`else
      // Without the watchdog the transfer waits indefinitely
      req = 4'b0010;
      wait_start(ok);
      req = '0;
      repeat (200) tick();
      chk("nowdog_busy", 64'(busy), 64'd1);
      chk("nowdog_gnt", 64'(gnt), 64'b0010);
      push_exp(4'b0010, 12'h123, 1'b0);
      spi_done = 1'b1;
      spi_dout = 12'h123;
      tick();
      spi_done = 1'b0;
      tick();
      $display("txn no-watchdog: gnt=0010 rsp=123 after 200 idle cycles");
`endif

      tick();
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
